slow_tick_timer: RTL and testbench
==================================

Name: slow_tick_timer

Overview:
- Consumer end of the slow-clock interface: takes the 1 Hz square wave from the divider as an asynchronous level, synchronizes it into Clk, and edge-detects it into a one-cycle tick.
- Uses those ticks to run the Frogger round countdown, with start, pause, expiry and decimal digit outputs for the HUD.
- Includes a watchdog that flags a missing 1 Hz source.

Parameters:
START_SECS, 30, round length in seconds loaded on start; legal range 1..99.
SYNC_STAGES, 2, synchronizer flops on clk_1Hz_in; legal range 2..4.
TIMEOUT_CYCLES, 60_000_000, Clk cycles without a tick before tick_lost asserts; legal range >= 2.

Ports:
Clk  input  1  system clock (50 MHz).
reset_n  input  1  asynchronous, active-low reset.
clk_1Hz_in  input  1  slow square wave from the divider; asynchronous to Clk.
start  input  1  one-cycle pulse that (re)loads and starts the round.
pause  input  1  level; freezes the countdown while high.
tick  output  1  one-cycle pulse per detected rising edge of clk_1Hz_in.
secs_left  output  8  remaining seconds, binary.
tens  output  4  decimal tens digit of secs_left.
ones  output  4  decimal ones digit of secs_left.
running  output  1  high in RUN state only.
expired  output  1  one-cycle pulse when the count reaches 0.
tick_lost  output  1  watchdog flag.

Behaviour:
- Reset (reset_n low, asynchronous): all synchronizer flops and the edge-history flop go to 0; state IDLE; secs_left, tens, ones = 0; running, expired, tick = 0; tick_lost = 0; watchdog counter = 0. Deassertion is synchronous to Clk (upstream reset synchronizer).
- Reset mid-round: abandons the round immediately; no expired pulse.
- Synchronizer: chain of SYNC_STAGES flops, plus one history flop.
  - tick = registered (sync_out & ~history).
  - A clean 0->1 change on clk_1Hz_in that meets setup before edge E gives tick high for exactly the cycle after edge E+SYNC_STAGES.
  - Falling edges produce no tick.
  - tick is generated in every state.
- States: IDLE, RUN, PAUSED, DONE. Priority: reset > start > pause > tick.
  - Any state, start=1: secs_left <= START_SECS; next state RUN. A tick in the same cycle is ignored.
  - IDLE: hold secs_left = 0; ignore pause and tick.
  - RUN, pause=1: go to PAUSED; secs_left unchanged, even if tick=1 in that cycle.
  - RUN, tick=1, secs_left > 1: secs_left decrements by 1.
  - RUN, tick=1, secs_left == 1: secs_left <= 0; expired = 1 for the next cycle only; next state DONE.
  - PAUSED: ticks ignored; pause=0 returns to RUN at the next edge, where the next tick decrements.
  - DONE: hold 0 until start; pause and tick ignored.
- running = 1 exactly when state is RUN, registered, updating at the same edge as the state.
- tens/ones: registered, updated at the same edge as secs_left; always equal secs_left/10 and secs_left%10. Values above 99 are unreachable.
- Watchdog: counter increments each Clk cycle and clears on tick.
  - When the count reaches TIMEOUT_CYCLES-1, tick_lost <= 1 and the counter saturates there.
  - tick_lost clears at the edge where the next tick is seen.
  - Independent of the countdown state; start does not clear it.
- Simultaneous start and expiry edge: start wins; no expired pulse; reload to START_SECS.

Test Plan:
- Params START_SECS=3, SYNC_STAGES=2, TIMEOUT_CYCLES=20; clk_1Hz_in period 10 cycles (toggles every 5). After reset release, all outputs = 0; tick first high 3 cycles after the first input rise; tick never high after a falling edge.
- start pulse -> running=1 next cycle, secs_left=3, tens=0, ones=3. Ticks then give 2, 1, 0; expired high exactly one cycle alongside secs_left=0; running=0; state holds 0 through 3 more ticks.
- Pause: start, hold pause=1 across 2 ticks -> secs_left stays 3, running=0. Release -> next tick gives 2.
- start coincident with a tick while secs_left=1 -> secs_left=3, no expired pulse. pause coincident with a tick in RUN -> no decrement.
- Hold clk_1Hz_in at 0 -> tick_lost=1 exactly 20 cycles after the last tick, stays 1. Resume the input -> tick_lost=0 in the same cycle tick pulses.
- START_SECS=42: after start, tens=4, ones=2; after one tick, tens=4, ones=1. Assert reset_n=0 mid-count -> all outputs 0 asynchronously, no expired pulse.

Source files
------------

// File: rtl/slow_tick_timer.sv
// slow_tick_timer
// Brings the asynchronous 1 Hz square wave into the Clk domain, turns each
// rising edge into a one-cycle tick, and uses the ticks to run the round
// countdown shown on the HUD. A watchdog flags a missing 1 Hz source.
//
// Ports
//   Clk          system clock
//   reset_n      asynchronous active-low reset (deassertion synchronous to Clk)
//   clk_1Hz_in   slow square wave, asynchronous to Clk
//   start        one-cycle pulse: reload START_SECS and run
//   pause        level: freeze the countdown while high
//   tick         one-cycle pulse per rising edge of clk_1Hz_in
//   secs_left    remaining seconds, binary
//   tens, ones   decimal digits of secs_left
//   running      high in RUN only
//   expired      one-cycle pulse when the count reaches 0
//   tick_lost    watchdog flag: no tick for TIMEOUT_CYCLES cycles

module slow_tick_timer #(
  parameter int START_SECS     = 30,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 60_000_000
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       clk_1Hz_in,
  input  logic       start,
  input  logic       pause,
  output logic       tick,
  output logic [7:0] secs_left,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       expired,
  output logic       tick_lost
);

  // state     | meaning
  // ----------+-----------------------------------------------
  // ST_IDLE   | no round since reset; secs_left held at 0
  // ST_RUN    | counting down, one second per tick
  // ST_PAUSED | countdown frozen while pause is high
  // ST_DONE   | round expired; secs_left held at 0 until start
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] LP_START = 8'(START_SECS);
  localparam int         WD_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] LP_WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Synchronizer and rising-edge detect
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_tick;
  logic                   w_sync_out;
  logic                   w_rise;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_rise     = w_sync_out & ~r_hist;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], clk_1Hz_in};
      r_hist <= w_sync_out;
      r_tick <= w_rise;
    end
  end

  assign tick = r_tick;

  // ---------------------------------------------------------------------
  // Watchdog
  // Cleared by the same edge that raises tick, so tick_lost drops in the
  // very cycle the recovered tick pulses.
  // ---------------------------------------------------------------------
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_tick_lost;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt    <= '0;
      r_tick_lost <= 1'b0;
    end else if (w_rise) begin
      r_wd_cnt    <= '0;
      r_tick_lost <= 1'b0;
    end else if (r_wd_cnt == LP_WD_LAST) begin
      r_tick_lost <= 1'b1;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign tick_lost = r_tick_lost;

  // ---------------------------------------------------------------------
  // Countdown FSM
  // ---------------------------------------------------------------------
  state_t     r_state;
  logic [7:0] r_secs;
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       r_running;
  logic       r_expired;

  state_t     w_state_nxt;
  logic [7:0] w_secs_nxt;
  logic       w_expired_nxt;
  logic [3:0] w_tens_nxt;
  logic [3:0] w_ones_nxt;

  always_comb begin
    w_state_nxt   = r_state;
    w_secs_nxt    = r_secs;
    w_expired_nxt = 1'b0;

    if (start) begin
      // start outranks pause and tick, including a tick that would expire
      w_secs_nxt  = LP_START;
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_secs_nxt = 8'd0;
        end
        ST_RUN: begin
          if (pause) begin
            w_state_nxt = ST_PAUSED;
          end else if (r_tick) begin
            if (r_secs > 8'd1) begin
              w_secs_nxt = r_secs - 8'd1;
            end else begin
              w_secs_nxt    = 8'd0;
              w_expired_nxt = 1'b1;
              w_state_nxt   = ST_DONE;
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DONE: begin
          w_secs_nxt = 8'd0;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_secs_nxt  = 8'd0;
        end
      endcase
    end
  end

  // secs_left never exceeds 99, so the digit split always fits in 4 bits
  assign w_tens_nxt = 4'(w_secs_nxt / 8'd10);
  assign w_ones_nxt = 4'(w_secs_nxt % 8'd10);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_secs    <= 8'd0;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_secs    <= w_secs_nxt;
      r_tens    <= w_tens_nxt;
      r_ones    <= w_ones_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_expired <= w_expired_nxt;
    end
  end

  assign secs_left = r_secs;
  assign tens      = r_tens;
  assign ones      = r_ones;
  assign running   = r_running;
  assign expired   = r_expired;

endmodule

// File: tb/tb_slow_tick_timer.sv
module tb_slow_tick_timer;

  logic       Clk = 1'b0;
  logic       reset_n_a = 1'b1;
  logic       reset_n_b = 1'b1;
  logic       clk_1Hz_in;
  logic       start_a = 1'b0;
  logic       pause_a = 1'b0;
  logic       start_b = 1'b0;
  logic       pause_b = 1'b0;

  logic       tick_a, running_a, expired_a, tick_lost_a;
  logic [7:0] secs_a;
  logic [3:0] tens_a, ones_a;
  logic       tick_b, running_b, expired_b, tick_lost_b;
  logic [7:0] secs_b;
  logic [3:0] tens_b, ones_b;

  bit slow_auto   = 1'b0;
  bit slow_manual = 1'b0;
  int slow_cnt;

  typedef struct {
    string tag;
    int    exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  slow_tick_timer #(
    .START_SECS(3), .SYNC_STAGES(2), .TIMEOUT_CYCLES(20)
  ) u_dut_a (
    .Clk(Clk), .reset_n(reset_n_a), .clk_1Hz_in(clk_1Hz_in),
    .start(start_a), .pause(pause_a), .tick(tick_a),
    .secs_left(secs_a), .tens(tens_a), .ones(ones_a),
    .running(running_a), .expired(expired_a), .tick_lost(tick_lost_a)
  );

  slow_tick_timer #(
    .START_SECS(42), .SYNC_STAGES(2), .TIMEOUT_CYCLES(20)
  ) u_dut_b (
    .Clk(Clk), .reset_n(reset_n_b), .clk_1Hz_in(clk_1Hz_in),
    .start(start_b), .pause(pause_b), .tick(tick_b),
    .secs_left(secs_b), .tens(tens_b), .ones(ones_b),
    .running(running_b), .expired(expired_b), .tick_lost(tick_lost_b)
  );

  initial begin
    forever #5 Clk = ~Clk;
  end

  // slow source: follows slow_manual, or toggles every 5 Clk cycles in auto
  initial begin
    clk_1Hz_in = 1'b0;
    slow_cnt   = 0;
    forever begin
      @(posedge Clk);
      #2;
      if (!slow_auto) begin
        clk_1Hz_in = slow_manual;
        slow_cnt   = 0;
      end else if (slow_cnt == 4) begin
        slow_cnt   = 0;
        clk_1Hz_in = ~clk_1Hz_in;
      end else begin
        slow_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running, expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input int obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", obs, -1);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.exp);
    end
  endtask

  task automatic push_outs(input string pfx, input int secs, input int run, input int expd);
    push_exp({pfx, "_secs"}, secs);
    push_exp({pfx, "_tens"}, secs / 10);
    push_exp({pfx, "_ones"}, secs % 10);
    push_exp({pfx, "_running"}, run);
    push_exp({pfx, "_expired"}, expd);
  endtask

  task automatic pop_outs_a();
    pop_chk(int'(secs_a));
    pop_chk(int'(tens_a));
    pop_chk(int'(ones_a));
    pop_chk(int'(running_a));
    pop_chk(int'(expired_a));
  endtask

  task automatic pop_outs_b();
    pop_chk(int'(secs_b));
    pop_chk(int'(tens_b));
    pop_chk(int'(ones_b));
    pop_chk(int'(running_b));
    pop_chk(int'(expired_b));
  endtask

  // drive point / sample point: 1 ns after the rising edge
  task automatic next_cyc();
    @(posedge Clk);
    #1;
  endtask

  // returns at a drive point where tick is high, so the next edge consumes it
  task automatic wait_tick(input bit sel_b);
    int n;
    n = 0;
    while (((sel_b ? tick_b : tick_a) !== 1'b1) && (n < 40)) begin
      next_cyc();
      n++;
    end
    if ((sel_b ? tick_b : tick_a) !== 1'b1) begin
      check_val(sel_b ? "wait_tick_b" : "wait_tick_a", 0, 1);
    end
  endtask

  initial begin
    #1;
    reset_n_a = 1'b0;
    reset_n_b = 1'b0;
    #2;
    // asynchronous reset visible before any clock edge
    push_outs("rst", 0, 0, 0);
    push_exp("rst_tick", 0);
    push_exp("rst_lost", 0);
    pop_outs_a();
    pop_chk(int'(tick_a));
    pop_chk(int'(tick_lost_a));

    repeat (3) next_cyc();
    reset_n_a = 1'b1;
    reset_n_b = 1'b1;
    next_cyc();
    push_outs("post_rst", 0, 0, 0);
    push_exp("post_rst_tick", 0);
    push_exp("post_rst_lost", 0);
    pop_outs_a();
    pop_chk(int'(tick_a));
    pop_chk(int'(tick_lost_a));

    // first rise: tick on the 3rd sample only
    slow_manual = 1'b1;
    push_exp("rise_c1", 0);
    push_exp("rise_c2", 0);
    push_exp("rise_c3", 1);
    push_exp("rise_c4", 0);
    push_exp("rise_c5", 0);
    for (int i = 0; i < 5; i++) begin
      next_cyc();
      pop_chk(int'(tick_a));
    end

    // falling edge: never a tick
    slow_manual = 1'b0;
    for (int i = 0; i < 6; i++) push_exp("fall_tick", 0);
    for (int i = 0; i < 6; i++) begin
      next_cyc();
      pop_chk(int'(tick_a));
    end

    // full countdown to expiry
    slow_auto = 1'b1;
    push_outs("start", 3, 1, 0);
    start_a = 1'b1;
    next_cyc();
    start_a = 1'b0;
    pop_outs_a();

    push_outs("cnt2", 2, 1, 0);
    wait_tick(1'b0);
    next_cyc();
    pop_outs_a();

    push_outs("cnt1", 1, 1, 0);
    wait_tick(1'b0);
    next_cyc();
    pop_outs_a();

    push_outs("cnt0", 0, 0, 1);
    wait_tick(1'b0);
    next_cyc();
    pop_outs_a();

    push_outs("exp_once", 0, 0, 0);
    next_cyc();
    pop_outs_a();

    for (int i = 0; i < 3; i++) begin
      push_outs("done_hold", 0, 0, 0);
      wait_tick(1'b0);
      next_cyc();
      pop_outs_a();
    end

    // pause across two ticks
    push_outs("p_start", 3, 1, 0);
    start_a = 1'b1;
    next_cyc();
    start_a = 1'b0;
    pop_outs_a();
    pause_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_tick(1'b0);
      next_cyc();
    end
    push_outs("paused", 3, 0, 0);
    pop_outs_a();

    pause_a = 1'b0;
    push_outs("resume", 3, 1, 0);
    next_cyc();
    pop_outs_a();
    push_outs("resume_dec", 2, 1, 0);
    wait_tick(1'b0);
    next_cyc();
    pop_outs_a();

    // start coincident with the tick that would expire
    push_outs("to1", 1, 1, 0);
    wait_tick(1'b0);
    next_cyc();
    pop_outs_a();
    push_outs("start_vs_exp", 3, 1, 0);
    wait_tick(1'b0);
    start_a = 1'b1;
    next_cyc();
    start_a = 1'b0;
    pop_outs_a();
    push_exp("start_vs_exp_late", 0);
    next_cyc();
    pop_chk(int'(expired_a));

    // pause coincident with a tick
    push_outs("pause_vs_tick", 3, 0, 0);
    wait_tick(1'b0);
    pause_a = 1'b1;
    next_cyc();
    pause_a = 1'b0;
    pop_outs_a();
    next_cyc();

    // watchdog: source held low after a tick
    wait_tick(1'b0);
    push_exp("wd_at_tick", 0);
    pop_chk(int'(tick_lost_a));
    slow_auto   = 1'b0;
    slow_manual = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      push_exp("wd_quiet", 0);
      next_cyc();
      pop_chk(int'(tick_lost_a));
    end
    push_exp("wd_20", 1);
    next_cyc();
    pop_chk(int'(tick_lost_a));
    for (int i = 0; i < 3; i++) begin
      push_exp("wd_sticky", 1);
      next_cyc();
      pop_chk(int'(tick_lost_a));
    end

    // source resumes: tick_lost drops in the tick cycle
    slow_manual = 1'b1;
    push_exp("wd_r1_tick", 0); push_exp("wd_r1_lost", 1);
    push_exp("wd_r2_tick", 0); push_exp("wd_r2_lost", 1);
    push_exp("wd_r3_tick", 1); push_exp("wd_r3_lost", 0);
    push_exp("wd_r4_tick", 0); push_exp("wd_r4_lost", 0);
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      pop_chk(int'(tick_a));
      pop_chk(int'(tick_lost_a));
    end

    // START_SECS = 42 instance: digits and asynchronous reset mid-count
    slow_auto = 1'b1;
    push_outs("b_start", 42, 1, 0);
    start_b = 1'b1;
    next_cyc();
    start_b = 1'b0;
    pop_outs_b();
    push_outs("b_dec", 41, 1, 0);
    wait_tick(1'b1);
    next_cyc();
    pop_outs_b();

    push_outs("b_arst", 0, 0, 0);
    push_exp("b_arst_tick", 0);
    push_exp("b_arst_lost", 0);
    #2;
    reset_n_b = 1'b0;
    #1;
    pop_outs_b();
    pop_chk(int'(tick_b));
    pop_chk(int'(tick_lost_b));
    for (int i = 0; i < 3; i++) begin
      push_outs("b_in_rst", 0, 0, 0);
      next_cyc();
      pop_outs_b();
    end
    reset_n_b = 1'b1;
    push_outs("b_after_rst", 0, 0, 0);
    next_cyc();
    pop_outs_b();

    check_val("sb_leftover", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
